// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU and response bus bundle for the ALU command sequencer
// slave  : sequencer view (takes commands, drives the ALU inputs, returns responses)
// master : environment view (issues commands, hosts the ALU, consumes responses)
// cmd_*  : valid/ready command (op, a, b, cin)
// alu_*  : ALU select/operand/carry outputs and the ALU result buses
// rsp_*  : valid/ready response (data, op echo, err), op_count of completed responses
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_cin;
    logic       alu_enable;
    logic [3:0] alu_select;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [3:0] alu_adder_out;
    logic       alu_cout;
    logic [1:0] alu_comparator_out;
    logic [3:0] alu_gray_out;
    logic [3:0] alu_and_out;
    logic       alu_anding_out;
    logic [3:0] alu_or_out;
    logic [3:0] alu_compl_out;
    logic       alu_inc_c;
    logic [3:0] alu_inc_s;
    logic [3:0] alu_dec_out;
    logic       alu_parity_out;
    logic       alu_oring_out;
    logic [7:0] alu_mul_out;
    logic [3:0] alu_bin_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_op;
    logic       rsp_err;
    logic [7:0] op_count;
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin,
        output cmd_ready,
        output alu_enable, alu_select, alu_a, alu_b, alu_cin,
        input  alu_adder_out, alu_cout, alu_comparator_out, alu_gray_out,
        input  alu_and_out, alu_anding_out, alu_or_out, alu_compl_out,
        input  alu_inc_c, alu_inc_s, alu_dec_out, alu_parity_out,
        input  alu_oring_out, alu_mul_out, alu_bin_out,
        output rsp_valid, rsp_data, rsp_op, rsp_err, op_count,
        input  rsp_ready
    );
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin,
        input  cmd_ready,
        input  alu_enable, alu_select, alu_a, alu_b, alu_cin,
        output alu_adder_out, alu_cout, alu_comparator_out, alu_gray_out,
        output alu_and_out, alu_anding_out, alu_or_out, alu_compl_out,
        output alu_inc_c, alu_inc_s, alu_dec_out, alu_parity_out,
        output alu_oring_out, alu_mul_out, alu_bin_out,
        input  rsp_valid, rsp_data, rsp_op, rsp_err, op_count,
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: one-at-a-time valid/ready front-end that fires the combinational ALU for one cycle
// clk : rising-edge clock
// rst : synchronous active-high reset, discards any in-flight command
// bus : alu_cmd_sequencer_if.slave (command port, ALU drive/results, response port, op_count)
module alu_cmd_sequencer (
    input logic clk,
    input logic rst,
    alu_cmd_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t     state;
    state_t     state_n;
    logic       accept;
    logic       done;
    logic       legal;
    logic [7:0] result;
    always_comb begin
        bus.cmd_ready  = (state == IDLE) && !rst;
        bus.alu_enable = state == EXEC;
        bus.rsp_valid  = state == RESP;
        accept         = bus.cmd_valid && bus.cmd_ready;
        done           = bus.rsp_valid && bus.rsp_ready;
        legal          = bus.cmd_op <= 4'd12;
        state_n = (state == IDLE) ? (accept ? (legal ? EXEC : RESP) : IDLE) :
                  (state == EXEC) ? RESP :
                  (done ? IDLE : RESP);
    end
    // Result buses are selected by the registered select, which is what the ALU is executing.
    always_comb begin
        result = 8'd0;
        case (bus.alu_select)
            4'd0:    result = {3'd0, bus.alu_cout, bus.alu_adder_out};
            4'd1:    result = {6'd0, bus.alu_comparator_out};
            4'd2:    result = {4'd0, bus.alu_gray_out};
            4'd3:    result = {4'd0, bus.alu_and_out};
            4'd4:    result = {7'd0, bus.alu_anding_out};
            4'd5:    result = {4'd0, bus.alu_or_out};
            4'd6:    result = {4'd0, bus.alu_compl_out};
            4'd7:    result = {3'd0, bus.alu_inc_c, bus.alu_inc_s};
            4'd8:    result = {4'd0, bus.alu_dec_out};
            4'd9:    result = {7'd0, bus.alu_parity_out};
            4'd10:   result = {7'd0, bus.alu_oring_out};
            4'd11:   result = bus.alu_mul_out;
            4'd12:   result = {4'd0, bus.alu_bin_out};
            default: result = 8'd0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.alu_select <= 4'd0;
            bus.alu_a      <= 4'd0;
            bus.alu_b      <= 4'd0;
            bus.alu_cin    <= 1'b0;
            bus.rsp_data   <= 8'd0;
            bus.rsp_op     <= 4'd0;
            bus.rsp_err    <= 1'b0;
            bus.op_count   <= 8'd0;
        end else begin
            state <= state_n;
            if (accept) begin
                bus.alu_select <= bus.cmd_op;
                bus.alu_a      <= bus.cmd_a;
                bus.alu_b      <= bus.cmd_b;
                bus.alu_cin    <= bus.cmd_cin;
                bus.rsp_op     <= bus.cmd_op;
                bus.rsp_err    <= !legal;
                bus.rsp_data   <= 8'd0;
            end
            if (state == EXEC)
                bus.rsp_data <= result;
            if (done)
                bus.op_count <= bus.op_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed self-checking bench for alu_cmd_sequencer with a behavioural ALU
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int rv_cnt = 0;
    int hs_cnt = 0;
    int cyc = 0;
    int exp_cnt = 0;
    int acc_q[$];
    logic [7:0] rsp_q[$];
    alu_cmd_sequencer_if bus ();
    alu_cmd_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // Behavioural ALU; outputs are zero unless enabled so late or early capture shows up.
    always_comb begin
        logic [4:0] s;
        logic [4:0] inc;
        s   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_cin};
        inc = {1'b0, bus.alu_a} + 5'd1;
        bus.alu_adder_out      = bus.alu_enable ? s[3:0] : 4'd0;
        bus.alu_cout           = bus.alu_enable ? s[4] : 1'b0;
        bus.alu_comparator_out = bus.alu_enable ? {bus.alu_a > bus.alu_b, bus.alu_a < bus.alu_b} : 2'd0;
        bus.alu_gray_out       = bus.alu_enable ? bus.alu_a ^ (bus.alu_a >> 1) : 4'd0;
        bus.alu_and_out        = bus.alu_enable ? bus.alu_a & bus.alu_b : 4'd0;
        bus.alu_anding_out     = bus.alu_enable ? &bus.alu_a : 1'b0;
        bus.alu_or_out         = bus.alu_enable ? bus.alu_a | bus.alu_b : 4'd0;
        bus.alu_compl_out      = bus.alu_enable ? ~bus.alu_a : 4'd0;
        bus.alu_inc_c          = bus.alu_enable ? inc[4] : 1'b0;
        bus.alu_inc_s          = bus.alu_enable ? inc[3:0] : 4'd0;
        bus.alu_dec_out        = bus.alu_enable ? bus.alu_a - 4'd1 : 4'd0;
        bus.alu_parity_out     = bus.alu_enable ? ^bus.alu_a : 1'b0;
        bus.alu_oring_out      = bus.alu_enable ? |bus.alu_a : 1'b0;
        bus.alu_mul_out        = bus.alu_enable ? {4'd0, bus.alu_a} * {4'd0, bus.alu_b} : 8'd0;
        bus.alu_bin_out        = bus.alu_enable ? bus.alu_a ^ (bus.alu_a >> 1) ^ (bus.alu_a >> 2) ^ (bus.alu_a >> 3) : 4'd0;
    end
    always @(posedge clk) begin
        if (bus.alu_enable) en_cnt++;
        if (bus.rsp_valid) rv_cnt++;
        if (bus.rsp_valid && bus.rsp_ready) begin
            hs_cnt++;
            rsp_q.push_back(bus.rsp_data);
        end
        if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
        cyc++;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic cin);
        int n;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_cin   = cin;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 20), 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask
    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask
    task automatic run_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic cin,
                          input logic [7:0] exp);
        int n;
        int e0;
        logic ill;
        ill = op > 4'd12;
        e0  = en_cnt;
        send(op, a, b, cin);
        wait_rsp(n);
        check("rsp_latency", 32'(n), ill ? 1'b0 : 1'b1);
        check("enable_cycles", 32'(en_cnt - e0), ill ? 1'b0 : 1'b1);
        check("rsp_data", 32'(bus.rsp_data), 32'(exp));
        check("rsp_op", 32'(bus.rsp_op), 32'(op));
        check("rsp_err", 32'(bus.rsp_err), 32'(ill));
        check("busy_ready", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        exp_cnt++;
        check("rsp_cleared", 32'(bus.rsp_valid), 0);
        check("op_count", 32'(bus.op_count), 32'(exp_cnt[7:0]));
    endtask
    logic [3:0] t_op  [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd12, 4'd0, 4'd11, 4'd0, 4'd9};
    logic [3:0] t_a   [12] = '{4'h3, 4'h6, 4'hC, 4'hF, 4'hC, 4'h5, 4'h2, 4'h6, 4'h5, 4'h3, 4'hF, 4'h3};
    logic [3:0] t_b   [12] = '{4'h9, 4'h0, 4'hA, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h3, 4'h4, 4'hF, 4'h0};
    logic       t_cin [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] t_exp [12] = '{8'h01, 8'h05, 8'h08, 8'h01, 8'h0E, 8'h0A, 8'h01, 8'h04, 8'h09, 8'h0C, 8'h1F, 8'h00};
    logic [3:0] b_op  [3]  = '{4'd7, 4'd8, 4'd9};
    logic [3:0] b_a   [3]  = '{4'hF, 4'h0, 4'h7};
    logic [7:0] b_exp [3]  = '{8'h10, 8'h0F, 8'h01};
    initial begin
        int n;
        int a0;
        int r0;
        int h0;
        int v0;
        int e0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_a     = 4'd0;
        bus.cmd_b     = 4'd0;
        bus.cmd_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_alu_enable", 32'(bus.alu_enable), 0);
        check("rst_alu_select", 32'(bus.alu_select), 0);
        check("rst_rsp_data", 32'(bus.rsp_data), 0);
        check("rst_op_count", 32'(bus.op_count), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.cmd_ready), 1);
        bus.rsp_ready = 1'b1;
        run_op(4'd0, 4'd9, 4'd8, 1'b0, 8'h11);
        // Stalled response holds everything steady
        bus.rsp_ready = 1'b0;
        send(4'd11, 4'hF, 4'hF, 1'b0);
        wait_rsp(n);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(bus.rsp_valid), 1);
            check("stall_data", 32'(bus.rsp_data), 32'h00E1);
            check("stall_ready", 32'(bus.cmd_ready), 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        check("stall_release", 32'(bus.rsp_valid), 0);
        check("stall_idle", 32'(bus.cmd_ready), 1);
        check("stall_count", 32'(bus.op_count), 32'(exp_cnt[7:0]));
        run_op(4'd14, 4'h5, 4'hA, 1'b1, 8'h00);
        run_op(4'd13, 4'h1, 4'h2, 1'b0, 8'h00);
        // Back-to-back with valid held high
        a0 = acc_q.size();
        r0 = rsp_q.size();
        for (int i = 0; i < 3; i++) begin
            bus.cmd_op    = b_op[i];
            bus.cmd_a     = b_a[i];
            bus.cmd_b     = 4'd0;
            bus.cmd_cin   = 1'b0;
            bus.cmd_valid = 1'b1;
            n = 0;
            while (!bus.cmd_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        n = 0;
        while (rsp_q.size() < r0 + 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_rsp_count", 32'(rsp_q.size() - r0), 3);
        check("b2b_acc_count", 32'(acc_q.size() - a0), 3);
        for (int i = 0; i < 3; i++)
            if (rsp_q.size() > r0 + i) check("b2b_data", 32'(rsp_q[r0 + i]), 32'(b_exp[i]));
        for (int i = 1; i < 3; i++)
            if (acc_q.size() > a0 + i) check("b2b_interval", 32'(acc_q[a0 + i] - acc_q[a0 + i - 1]), 3);
        exp_cnt += 3;
        check("b2b_count", 32'(bus.op_count), 32'(exp_cnt[7:0]));
        for (int i = 0; i < 12; i++)
            run_op(t_op[i], t_a[i], t_b[i], t_cin[i], t_exp[i]);
        // 256 responses bring op_count back round to its starting value
        h0 = hs_cnt;
        bus.cmd_op    = 4'd14;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (hs_cnt - h0 < 256 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b0;
        exp_cnt += 256;
        check("wrap_responses", 32'(hs_cnt - h0), 256);
        check("wrap_count", 32'(bus.op_count), 32'(exp_cnt[7:0]));
        // Reset during EXEC and during RESP
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_cnt = 0;
        check("rerst_count", 32'(bus.op_count), 0);
        h0 = hs_cnt;
        v0 = rv_cnt;
        e0 = en_cnt;
        send(4'd6, 4'h5, 4'h0, 1'b0);
        check("exec_entered", 32'(bus.alu_enable), 1);
        rst = 1'b1;
        @(negedge clk);
        check("exec_rst_enable", 32'(bus.alu_enable), 0);
        check("exec_rst_select", 32'(bus.alu_select), 0);
        check("exec_rst_a", 32'(bus.alu_a), 0);
        check("exec_rst_ready", 32'(bus.cmd_ready), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("exec_rst_no_rsp", 32'(rv_cnt - v0), 0);
        check("exec_rst_one_en", 32'(en_cnt - e0), 1);
        check("exec_rst_idle", 32'(bus.cmd_ready), 1);
        bus.rsp_ready = 1'b0;
        send(4'd11, 4'h2, 4'h3, 1'b0);
        wait_rsp(n);
        check("resp_entered", 32'(bus.rsp_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check("resp_rst_valid", 32'(bus.rsp_valid), 0);
        check("resp_rst_data", 32'(bus.rsp_data), 0);
        check("resp_rst_op", 32'(bus.rsp_op), 0);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_handshake", 32'(hs_cnt - h0), 0);
        check("rst_count_zero", 32'(bus.op_count), 0);
        run_op(4'd5, 4'h3, 4'h4, 1'b0, 8'h07);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
